// File: rtl/dest_tracker.sv
// dest_tracker: in-order return-destination queue for a slave-side NoC
// translator. Every accepted request leaves its return {dst, vc} and its
// reply length (beats-1). The head entry is shown to the reply path and is
// retired only after its last reply beat has been consumed.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_dst_in/i_vc_in      return destination / VC of the incoming request
//   i_len_in              reply length of the incoming request, beats-1
//   i_valid_in            request present
//   i_ready_out           a free slot exists (registered decode)
//   o_dst_out/o_vc_out    head entry destination / VC, 0 when empty
//   o_valid_out           head entry present
//   o_last_out            current beat is the last beat of the head entry
//   o_valid_in            reply beat consumed this cycle
//   o_count_out           number of entries held
//   o_overflow_out        sticky: request presented while full
//   o_underflow_out       sticky: beat consumed while empty
module dest_tracker #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int LEN_WIDTH        = 3,
  parameter int DEPTH            = 12,
  parameter int CNT_WIDTH        = $clog2(DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDRESS_WIDTH-1:0]    i_dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] i_vc_in,
  input  logic [LEN_WIDTH-1:0]        i_len_in,
  input  logic                        i_valid_in,
  output logic                        i_ready_out,
  output logic [ADDRESS_WIDTH-1:0]    o_dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0] o_vc_out,
  output logic                        o_valid_out,
  output logic                        o_last_out,
  input  logic                        o_valid_in,
  output logic [CNT_WIDTH-1:0]        o_count_out,
  output logic                        o_overflow_out,
  output logic                        o_underflow_out
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0]    dst;
    logic [VC_ADDRESS_WIDTH-1:0] vc;
    logic [LEN_WIDTH-1:0]        len;
  } entry_t;

  entry_t               mem [DEPTH];
  entry_t               head;
  logic [PTR_W-1:0]     wptr, rptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] beat;
  logic                 ovf, unf;
  logic                 push, consume, pop;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign head        = mem[rptr];
  assign i_ready_out = (cnt != CNT_WIDTH'(DEPTH));
  assign o_valid_out = (cnt != '0);
  assign o_count_out = cnt;
  assign o_last_out  = o_valid_out & (beat == head.len);
  assign o_dst_out   = o_valid_out ? head.dst : '0;
  assign o_vc_out    = o_valid_out ? head.vc  : '0;

  assign o_overflow_out  = ovf;
  assign o_underflow_out = unf;

  // ready is a registered decode, so a pop while full does not admit a push
  // in the same cycle.
  assign push    = i_valid_in & i_ready_out;
  assign consume = o_valid_in & o_valid_out;
  assign pop     = consume & o_last_out;

  // Payload storage carries no reset; contents are meaningless once cnt=0.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{dst: i_dst_in, vc: i_vc_in, len: i_len_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      beat <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop) begin
        rptr <= ptr_inc(rptr);
        beat <= '0;
      end else if (consume) begin
        beat <= beat + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_WIDTH'(1);
        2'b01:   cnt <= cnt - CNT_WIDTH'(1);
        default: cnt <= cnt;
      endcase
      if (i_valid_in & ~i_ready_out) ovf <= 1'b1;
      if (o_valid_in & ~o_valid_out) unf <= 1'b1;
    end
  end

endmodule
